ct_ifu_spsram512x44_ctrl: RTL and testbench



---
 rtl/ct_ifu_spsram512x44_ctrl.sv | 146 ++++++++++++++
 tb/tb_ct_ifu_spsram512x44_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_spsram512x44_ctrl.sv
// rtl/ct_ifu_spsram512x44_ctrl.sv - initiator-side controller for a 512x44 single-port IFU SRAM
//
// Purpose:
//   Turns a valid/ready request stream into the SRAM pin protocol.
//   The SRAM pins are active-low CEN, active-low GWEN and a per-bit active-low WEN.
//   Read data comes back one cycle after the accept, with a registered valid and a hold register.
//   A hardware clear sweep writes INIT_DATA to every entry after reset and on flush.
//
// Ports:
//   forever_cpuclk   clock; also the SRAM clock
//   cpu_rst          synchronous reset, active-high
//   flush_req        one-cycle pulse that starts a clear sweep
//   init_busy        high while a clear sweep runs
//   req_vld/req_rdy  request handshake
//   req_wr           1 = write, 0 = read
//   req_addr         entry address
//   req_wdata        write data
//   req_wmask        per-bit write enable, 1 = write this bit
//   rsp_vld          one-cycle read data valid
//   rsp_data         read data; holds the last read value
//   sram_a           SRAM address pin
//   sram_cen         SRAM chip enable pin (active-low)
//   sram_gwen        SRAM global write enable pin (active-low)
//   sram_wen         SRAM per-bit write enable pins (active-low)
//   sram_d           SRAM data-in pins
//   sram_q           SRAM data-out pins

module ct_ifu_spsram512x44_ctrl #(
    parameter int                  ADDR_WIDTH  = 9,
    parameter int                  DATA_WIDTH  = 44,
    parameter int                  DEPTH       = 512,
    parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0,
    parameter bit                  INIT_ON_RST = 1'b1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpu_rst,
    input  logic                  flush_req,
    output logic                  init_busy,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t                RST_STATE = INIT_ON_RST ? ST_INIT : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_rsp_vld;
    logic [DATA_WIDTH-1:0]   r_hold;

    logic                    w_acc;
    logic                    w_rd_acc;
    logic                    w_wr_acc;

    // Requests are refused in the flush cycle and while reset is held.
    assign req_rdy   = (r_state == ST_READY) & ~flush_req & ~cpu_rst;
    assign init_busy = (r_state == ST_INIT);

    assign w_acc    = req_vld & req_rdy;
    assign w_rd_acc = w_acc & ~req_wr;
    // A write with an all-zero mask is accepted but never reaches the macro.
    assign w_wr_acc = w_acc & req_wr & (|req_wmask);

    // The valid is gated by reset so that a response pending at reset is dropped.
    // The SRAM Q pins are passed straight through in the response cycle.
    assign rsp_vld  = r_rsp_vld & ~cpu_rst;
    assign rsp_data = rsp_vld ? sram_q : r_hold;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (!cpu_rst) begin
            if (r_state == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = r_cnt;
                sram_d    = INIT_DATA;
            end else if (w_rd_acc) begin
                sram_cen = 1'b0;
                sram_a   = req_addr;
            end else if (w_wr_acc) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_a    = req_addr;
                sram_d    = req_wdata;
                sram_wen  = ~req_wmask;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpu_rst) begin
            r_state   <= RST_STATE;
            r_cnt     <= '0;
            r_rsp_vld <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_rsp_vld <= w_rd_acc;
            if (r_rsp_vld) begin
                r_hold <= sram_q;
            end
            case (r_state)
                ST_INIT: begin
                    // A flush mid-sweep restarts the sweep from entry 0.
                    // This keeps the sweep length at DEPTH cycles from the last flush.
                    if (flush_req) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (flush_req) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_ifu_spsram512x44_ctrl.sv
// tb/tb_ct_ifu_spsram512x44_ctrl.sv - scoreboard bench for the 512x44 IFU SRAM controller

module tb_ct_ifu_spsram512x44_ctrl;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        flush_req;
    logic        init_busy;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wr;
    logic [8:0]  req_addr;
    logic [43:0] req_wdata;
    logic [43:0] req_wmask;
    logic        rsp_vld;
    logic [43:0] rsp_data;
    logic [8:0]  sram_a;
    logic        sram_cen;
    logic        sram_gwen;
    logic [43:0] sram_wen;
    logic [43:0] sram_d;
    logic [43:0] sram_q;

    always #5 clk = ~clk;

    ct_ifu_spsram512x44_ctrl dut (
        .forever_cpuclk (clk),
        .cpu_rst        (cpu_rst),
        .flush_req      (flush_req),
        .init_busy      (init_busy),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Behavioural SRAM macro
    logic [43:0] mem [0:511];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference contents and response scoreboard
    logic [43:0] ref_mem [0:511];
    logic [43:0] sb_q [$];
    logic        pend = 1'b0;
    logic [43:0] last_data = '0;

    always @(negedge clk) begin
        logic        exp_v;
        logic [43:0] e;
        exp_v = pend & ~cpu_rst;
        chk("rsp_vld", {63'd0, rsp_vld}, {63'd0, exp_v});
        if (pend) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                if (exp_v) begin
                    chk("rsp_data", {20'd0, rsp_data}, {20'd0, e});
                    last_data = e;
                end
            end
        end else if (!cpu_rst) begin
            chk("rsp_hold", {20'd0, rsp_data}, {20'd0, last_data});
        end
        pend = 1'b0;
        if (cpu_rst) last_data = '0;
        if (!cpu_rst && req_vld && req_rdy) begin
            if (req_wr) begin
                ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            end else begin
                sb_q.push_back(ref_mem[req_addr]);
                pend = 1'b1;
            end
        end
        if (cpu_rst || flush_req) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = 44'h0;
        end
    end

    logic        s_cen, s_gwen, s_rdy, s_vld;
    logic [43:0] s_wen, s_d;
    logic [8:0]  s_a;

    // Drive one request for one cycle; captures pins at the mid-cycle sample point.
    task automatic issue(input logic wr, input logic [8:0] a, input logic [43:0] d, input logic [43:0] m);
        req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
        @(negedge clk);
        s_cen = sram_cen; s_gwen = sram_gwen; s_wen = sram_wen; s_d = sram_d;
        s_a = sram_a; s_rdy = req_rdy; s_vld = rsp_vld;
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Follows a clear sweep from its first cycle; ends at the first READY sample point.
    task automatic sweep(input string tag);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        while (init_busy && n < 2000) begin
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 44'h0 ||
                sram_d !== 44'h0 || sram_a !== n[8:0] || req_rdy !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, 64'(n), 64'd512);
        chk({tag, "_pins"}, 64'(bad), 64'd0);
        chk({tag, "_rdy"}, {63'd0, req_rdy}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [43:0] rd, rm;
        cpu_rst = 1'b1; flush_req = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;

        repeat (2) step();
        @(negedge clk);
        chk("rst_cen", {63'd0, sram_cen}, 64'd1);
        chk("rst_rdy", {63'd0, req_rdy}, 64'd0);
        chk("rst_wen", {20'd0, sram_wen}, {20'd0, 44'hFFF_FFFF_FFFF});
        step();
        cpu_rst = 1'b0;

        // 1: post-reset sweep
        sweep("t1_sweep");
        chk("t1_rsp_data", {20'd0, rsp_data}, 64'd0);
        step();

        // 2: full write then read
        issue(1'b1, 9'h05A, 44'hABC_DEF0_1234, 44'hFFF_FFFF_FFFF);
        chk("t2_wr_cen", {63'd0, s_cen}, 64'd0);
        chk("t2_wr_gwen", {63'd0, s_gwen}, 64'd0);
        chk("t2_wr_wen", {20'd0, s_wen}, 64'd0);
        chk("t2_wr_d", {20'd0, s_d}, {20'd0, 44'hABC_DEF0_1234});
        issue(1'b0, 9'h05A, 44'h0, 44'h0);
        chk("t2_rd_gwen", {63'd0, s_gwen}, 64'd1);
        chk("t2_rd_a", {55'd0, s_a}, 64'h5A);
        @(negedge clk);
        chk("t2_rvld", {63'd0, rsp_vld}, 64'd1);
        chk("t2_rdata", {20'd0, rsp_data}, {20'd0, 44'hABC_DEF0_1234});
        step();
        @(negedge clk);
        chk("t2_hold_vld", {63'd0, rsp_vld}, 64'd0);
        chk("t2_hold", {20'd0, rsp_data}, {20'd0, 44'hABC_DEF0_1234});
        step();

        // 3: partial write and zero-mask write
        issue(1'b1, 9'h1FF, 44'hFFF_FFFF_FFFF, 44'h000_0000_FFFF);
        chk("t3_wen", {20'd0, s_wen}, {20'd0, 44'hFFF_FFFF_0000});
        issue(1'b0, 9'h1FF, 44'h0, 44'h0);
        @(negedge clk);
        chk("t3_rdata", {20'd0, rsp_data}, {20'd0, 44'h000_0000_FFFF});
        step();
        issue(1'b1, 9'h05A, 44'h0, 44'h0);
        chk("t3_nop_cen", {63'd0, s_cen}, 64'd1);
        chk("t3_nop_rdy", {63'd0, s_rdy}, 64'd1);
        issue(1'b0, 9'h05A, 44'h0, 44'h0);
        step();

        // 4: back-to-back reads
        issue(1'b1, 9'd1, 44'h111_1111_1111, 44'hFFF_FFFF_FFFF);
        issue(1'b1, 9'd2, 44'h222_2222_2222, 44'hFFF_FFFF_FFFF);
        issue(1'b1, 9'd3, 44'h333_3333_3333, 44'hFFF_FFFF_FFFF);
        issue(1'b0, 9'd1, 44'h0, 44'h0);
        issue(1'b0, 9'd2, 44'h0, 44'h0);
        rd[0] = s_vld;
        issue(1'b0, 9'd3, 44'h0, 44'h0);
        rd[1] = s_vld;
        @(negedge clk);
        rd[2] = rsp_vld;
        chk("t4_b2b", {61'd0, rd[2:0]}, 64'd7);
        chk("t4_last", {20'd0, rsp_data}, {20'd0, 44'h333_3333_3333});
        step();

        // random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else begin
                rd = {$urandom, $urandom};
                rm = ($urandom_range(0, 5) == 0) ? 44'h0 : 44'({$urandom, $urandom});
                issue(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), rd, rm);
            end
        end
        step();

        // 5: read then flush in the following cycle
        issue(1'b0, 9'd2, 44'h0, 44'h0);
        flush_req = 1'b1;
        @(negedge clk);
        chk("t5_vld", {63'd0, rsp_vld}, 64'd1);
        chk("t5_rdy", {63'd0, req_rdy}, 64'd0);
        step();
        flush_req = 1'b0;
        sweep("t5_sweep");
        step();
        for (int i = 0; i < 512; i++) issue(1'b0, 9'(i), 44'h0, 44'h0);
        step();
        step();
        chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);

        // 6: reset mid-sweep, then flush mid-sweep
        cpu_rst = 1'b1;
        step();
        cpu_rst = 1'b0;
        repeat (199) step();
        @(negedge clk);
        chk("t6_a199", {55'd0, sram_a}, 64'd199);
        step();
        cpu_rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_cen", {63'd0, sram_cen}, 64'd1);
        step();
        cpu_rst = 1'b0;
        sweep("t6_rst_sweep");
        step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (300) step();
        flush_req = 1'b1;
        @(negedge clk);
        chk("t6_a300", {55'd0, sram_a}, 64'd300);
        step();
        flush_req = 1'b0;
        sweep("t6_flush_sweep");
        step();
        issue(1'b0, 9'h05A, 44'h0, 44'h0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
